add16_sched: RTL and testbench

ADD16_SCHED -- requirements
Module: add16_sched

---
 rtl/add16_sched_pkg.sv | 14 +
 rtl/add16_sched_add4_slice.sv | 14 +
 rtl/add16_sched.sv | 156 +++++++++++++++
 tb/tb_add16_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add16_sched_pkg.sv
// Shared types for the time-shared slice adder: FSM states, slice width, requester id.
package add16_sched_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/add16_sched_add4_slice.sv
// Combinational 4-bit ripple adder; the scheduler reuses one instance for every slice.
module add4_slice
    import add16_sched_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add16_sched.sv
// Two-requester adder: round-robin accept, one 4-bit slice per cycle LSB first, held response.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; valid never waits on ready.
module add16_sched
    import add16_sched_pkg::*;
#(
    parameter int N_SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [4*N_SLICES-1:0] req0_a,
    input  logic [4*N_SLICES-1:0] req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [4*N_SLICES-1:0] req1_a,
    input  logic [4*N_SLICES-1:0] req1_b,
    input  logic                  req1_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [4*N_SLICES-1:0] rsp_sum,
    output logic                  rsp_cout,
    output req_id_t               rsp_id,
    output state_e                dbg_state
);

    localparam int W     = SLICE_W * N_SLICES;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    req_id_t          id_q, id_d, last_q, last_d;

    req_id_t          grant_id;
    logic             acc0, acc1;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;

    // Contention goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) grant_id = ~last_q;
        else                          grant_id = req1_valid;
    end

    assign req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !grant_id;
    assign req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid && grant_id;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        rsp_valid_d = rsp_valid_q;
        idx_d       = idx_q;
        id_d        = id_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (acc0 || acc1) begin
                    a_d     = acc1 ? req1_a : req0_a;
                    b_d     = acc1 ? req1_b : req0_b;
                    carry_d = acc1 ? req1_cin : req0_cin;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < N_SLICES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_cout;
                    rsp_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_RESP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Pointer resets to 1 so that req0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            idx_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            rsp_valid_q <= rsp_valid_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            last_q      <= last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add16_sched.sv
// Self-checking bench for add16_sched: directed scenarios plus randomized traffic vs a transaction model.
module tb_add16_sched;
    import add16_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk, rst_n;
    logic         req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout;
    logic [W-1:0] rsp_sum;
    req_id_t      rsp_id;
    state_e       dbg_state;

    add16_sched #(.N_SLICES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int acc_cyc  = 0;
    int m_mode   = 0;   // 0 waiting for a request, 1 computing, 2 holding a response
    int m_left   = 0;
    bit m_last   = 1'b1;
    logic [W+1:0] exp_q[$];   // {id, cout, sum}
    int acc_id_log[$];
    int acc_cyc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int unsigned s;
        s = int'(a) + int'(b) + int'(cin);
        return s[W:0];
    endfunction

    // One clock: called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        bit g, e0, e1, acc;
        state_e es;
        #1;
        if (req0_valid && req1_valid) g = !m_last;
        else                          g = req1_valid;
        e0 = rst_n && (m_mode == 0) && req0_valid && !g;
        e1 = rst_n && (m_mode == 0) && req1_valid && g;
        es = (m_mode == 0) ? ST_IDLE : (m_mode == 1) ? ST_ADD : ST_RESP;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("rsp_valid", rsp_valid, m_mode == 2);
        check("state", dbg_state, es);
        if (m_mode == 2) begin
            check("model_q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("rsp_sum", rsp_sum, exp_q[0][W-1:0]);
                check("rsp_cout", rsp_cout, exp_q[0][W]);
                check("rsp_id", rsp_id, exp_q[0][W+1]);
            end
        end
        acc = 1'b0;
        if (!rst_n) begin
            m_mode = 0;
            m_last = 1'b1;
            exp_q.delete();
        end else begin
            case (m_mode)
                0: if (e0 || e1) begin
                    if (g) exp_q.push_back({1'b1, ref_add(req1_a, req1_b, req1_cin)});
                    else   exp_q.push_back({1'b0, ref_add(req0_a, req0_b, req0_cin)});
                    m_last = g;
                    m_mode = 1;
                    m_left = N;
                    acc    = 1'b1;
                    acc_id_log.push_back(int'(g));
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
                default: if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    m_mode = 0;
                    n_done++;
                end
            endcase
        end
        @(posedge clk);
        cyc++;
        if (acc) begin
            acc_cyc = cyc;
            acc_cyc_log.push_back(cyc);
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_cin = 0; req1_cin = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic wait_rsp(input string tag, input int max_cycles);
        int n = 0;
        while (!rsp_valid && n < max_cycles) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, rsp_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        while (m_mode != 0 && n < 40) begin
            cycle();
            n++;
        end
        check("drain_timeout", m_mode == 0, 1);
        rsp_ready = 0;
    endtask

    task automatic one_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
        rsp_ready = 0;
        cycle();
        req0_valid = 0; req1_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ta, tb_v;
        logic         tc;
        logic [W:0]   tfull;
        int           start, n;

        idle_inputs();
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        check("rst_valid", rsp_valid, 0);
        rst_n = 1;
        idle_inputs();
        cycle();

        // Basic add on req0, fixed latency
        one_op(1'b0, 16'h1234, 16'h4321, 1'b0);
        wait_rsp("t030", 20);
        check("t030_latency", cyc - acc_cyc, N);
        check("t030_sum", rsp_sum, 16'h5555);
        check("t030_cout", rsp_cout, 0);
        check("t030_id", rsp_id, 0);
        rsp_ready = 1;
        cycle();
        rsp_ready = 0;

        // Full carry ripple on req1
        one_op(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        wait_rsp("t031", 20);
        check("t031_sum", rsp_sum, 16'h0000);
        check("t031_cout", rsp_cout, 1);
        check("t031_id", rsp_id, 1);
        rsp_ready = 1;
        cycle();
        rsp_ready = 0;

        // Continuous contention: alternating grants at maximum throughput
        acc_id_log.delete();
        acc_cyc_log.delete();
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        req0_a = 16'h0F0F; req0_b = 16'h7777; req0_cin = 1;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 0;
        n = 0;
        while (acc_id_log.size() < 4 && n < 60) begin
            cycle();
            n++;
        end
        check("t032_count", acc_id_log.size(), 4);
        for (int i = 0; i < acc_id_log.size() && i < 4; i++) begin
            check("t032_grant", acc_id_log[i], i % 2);
            if (i > 0) check("t032_spacing", acc_cyc_log[i] - acc_cyc_log[i-1], N + 2);
        end
        drain();

        // Back-pressure in RESP with operands toggling underneath
        ta = 16'hBEEF; tb_v = 16'h4111; tc = 1;
        tfull = ref_add(ta, tb_v, tc);
        one_op(1'b0, ta, tb_v, tc);
        wait_rsp("t033", 20);
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            #1;
            check("t033_hold_sum", rsp_sum, tfull[W-1:0]);
            check("t033_hold_cout", rsp_cout, tfull[W]);
            check("t033_no_ready", req0_ready | req1_ready, 0);
            cycle();
        end
        acc_id_log.delete();
        rsp_ready = 1;
        cycle();
        check("t033_no_accept_at_handshake", acc_id_log.size(), 0);
        rsp_ready = 0;
        cycle();
        check("t033_accept_after", acc_id_log.size(), 1);
        drain();

        // Reset during slice 2 of an operation from req1
        one_op(1'b1, 16'h9999, 16'h6667, 1'b0);
        cycle();
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        check("t034_valid_after_rst", rsp_valid, 0);
        req0_valid = 1; req1_valid = 1;
        req0_a = 16'h00FF; req0_b = 16'h0F01; req0_cin = 0;
        req1_a = 16'h1111; req1_b = 16'h2222; req1_cin = 1;
        #1;
        check("t034_ready0", req0_ready, 1);
        check("t034_ready1", req1_ready, 0);
        cycle();
        req0_valid = 0; req1_valid = 0;
        wait_rsp("t034", 20);
        check("t034_sum", rsp_sum, 16'h1000);
        check("t034_cout", rsp_cout, 0);
        check("t034_id", rsp_id, 0);
        drain();

        // Randomized traffic
        start = n_done;
        n = 0;
        while (n_done - start < 3000 && n < 60000) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp_ready  = ($urandom_range(0, 2) != 0);
            req0_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            req0_b = W'($urandom);
            req1_a = W'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            req0_cin = 1'($urandom);
            req1_cin = 1'($urandom);
            cycle();
            n++;
        end
        check("rand_completed", n_done - start >= 3000, 1);
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
